// File: rtl/cos_rom_pkg.sv
// Shared constants and the one-period sampled cosine table for the TX mapper ROMs.
// sym_word() maps a symbol value onto the +cos or -cos version of a table word.
package cos_rom_pkg;

   localparam int ROM_ADDR_W = 4;
   localparam int ROM_DEPTH  = 16;
   localparam int ROM_DATA_W = 16;

   // round(32767*cos(2*pi*k/16)); the peak is 32767 so the negated table never hits 16'h8000
   localparam logic signed [ROM_DATA_W-1:0] COS_TABLE [ROM_DEPTH] = '{
      16'sh7FFF, 16'sh7641, 16'sh5A82, 16'sh30FB,
      16'sh0000, 16'shCF05, 16'shA57E, 16'sh89BF,
      16'sh8001, 16'sh89BF, 16'shA57E, 16'shCF05,
      16'sh0000, 16'sh30FB, 16'sh5A82, 16'sh7641
   };

   function automatic logic signed [ROM_DATA_W-1:0] sym_word(
      input logic                  sym,
      input logic [ROM_ADDR_W-1:0] k
   );
      logic signed [ROM_DATA_W-1:0] word;
      word = COS_TABLE[k];
      return sym ? word : -word;
   endfunction

endpackage

// File: rtl/cos_symbol_rom.sv
// Registered 16x16 cosine waveform ROM, one instance per BPSK symbol value.
// SYMBOL=1 holds +cos, SYMBOL=0 holds -cos; one clock of read latency.
module cos_symbol_rom
   import cos_rom_pkg::*;
#(
   parameter int SYMBOL = 1,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              ena,
   input  logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] douta
);

   if (SYMBOL != 0 && SYMBOL != 1) begin : g_bad_symbol
      $error("cos_symbol_rom: SYMBOL must be 0 or 1");
   end
   if (ADDR_W != ROM_ADDR_W || DATA_W != ROM_DATA_W) begin : g_bad_width
      $error("cos_symbol_rom: table is fixed at 16 words of 16 bits");
   end

   localparam logic SYM_BIT = (SYMBOL == 1);

   // Reset clears the word at once and drops any read that was in flight
   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         douta <= '0;
      end else if (ena) begin
         douta <= sym_word(SYM_BIT, addra);
      end
   end

endmodule

// File: tb/tb_cos_symbol_rom.sv
// Bench for cos_symbol_rom: +cos and -cos instances side by side, expected words
// queued at drive time and popped one edge later when the registered word appears.
module tb_cos_symbol_rom;

   logic        clka;
   logic        reset;
   logic        ena;
   logic [3:0]  addra;
   logic [15:0] douta_pos;
   logic [15:0] douta_neg;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q_pos[$];
   logic [15:0] q_neg[$];
   logic [15:0] model_pos;
   logic [15:0] model_neg;

   logic [15:0] pos_tbl [16] = '{
      16'h7FFF, 16'h7641, 16'h5A82, 16'h30FB,
      16'h0000, 16'hCF05, 16'hA57E, 16'h89BF,
      16'h8001, 16'h89BF, 16'hA57E, 16'hCF05,
      16'h0000, 16'h30FB, 16'h5A82, 16'h7641
   };

   cos_symbol_rom #(.SYMBOL(1), .ADDR_W(4), .DATA_W(16)) dut_pos (
      .clka  (clka),
      .reset (reset),
      .ena   (ena),
      .addra (addra),
      .douta (douta_pos)
   );

   cos_symbol_rom #(.SYMBOL(0), .ADDR_W(4), .DATA_W(16)) dut_neg (
      .clka  (clka),
      .reset (reset),
      .ena   (ena),
      .addra (addra),
      .douta (douta_neg)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic check_value(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of stimulus between edges and queue what each ROM should show after the edge
   task automatic apply_stimulus(input logic en, input logic [3:0] addr);
      logic [15:0] neg_word;
      @(negedge clka);
      ena   = en;
      addra = addr;
      if (en) begin
         model_pos = pos_tbl[addr];
         neg_word  = ~pos_tbl[addr] + 16'd1;
         model_neg = neg_word;
      end
      q_pos.push_back(model_pos);
      q_neg.push_back(model_neg);
   endtask

   task automatic check_output(input string tag);
      logic [15:0] exp_pos;
      logic [15:0] exp_neg;
      @(posedge clka);
      #1;
      if (q_pos.size() == 0 || q_neg.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL %s scoreboard empty observed=%h expected=queued word", tag, douta_pos);
      end else begin
         exp_pos = q_pos.pop_front();
         exp_neg = q_neg.pop_front();
         check_value({tag, "_pos"}, douta_pos, exp_pos);
         check_value({tag, "_neg"}, douta_neg, exp_neg);
      end
   endtask

   task automatic step(input string tag, input logic en, input logic [3:0] addr);
      apply_stimulus(en, addr);
      check_output(tag);
   endtask

   initial begin
      reset     = 1'b0;
      ena       = 1'b0;
      addra     = 4'd0;
      model_pos = 16'h0000;
      model_neg = 16'h0000;

      #2;
      check_value("por_pos", douta_pos, 16'h0000);
      check_value("por_neg", douta_neg, 16'h0000);
      @(negedge clka);
      reset = 1'b1;

      step("load0", 1'b1, 4'd0);

      // Async reset with 7FFF held: output must clear before the next edge
      @(negedge clka);
      reset = 1'b0;
      #1;
      check_value("rst_async_pos", douta_pos, 16'h0000);
      check_value("rst_async_neg", douta_neg, 16'h0000);
      model_pos = 16'h0000;
      model_neg = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         ena   = 1'b1;
         addra = 4'd8;
         @(posedge clka);
         #1;
         check_value("rst_hold_pos", douta_pos, 16'h0000);
         check_value("rst_hold_neg", douta_neg, 16'h0000);
      end
      @(negedge clka);
      reset = 1'b1;

      for (int k = 0; k < 16; k++) begin
         step("sweep", 1'b1, 4'(k));
      end

      step("en_load", 1'b1, 4'd2);
      for (int i = 0; i < 4; i++) begin
         step("en_hold", 1'b0, 4'd8);
      end
      step("en_resume", 1'b1, 4'd8);

      step("wrap14", 1'b1, 4'd14);
      step("wrap15", 1'b1, 4'd15);
      step("wrap0",  1'b1, 4'd0);
      step("wrap1",  1'b1, 4'd1);

      // Mid-stream reset pulse between edges, then the read after release
      step("mid_a", 1'b1, 4'd2);
      step("mid_b", 1'b1, 4'd3);
      #2;
      reset = 1'b0;
      #1;
      check_value("mid_rst_pos", douta_pos, 16'h0000);
      check_value("mid_rst_neg", douta_neg, 16'h0000);
      model_pos = 16'h0000;
      model_neg = 16'h0000;
      reset = 1'b1;
      step("mid_after", 1'b1, 4'd5);
      check_value("mid_cf05", douta_pos, 16'hCF05);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
